// File: rtl/mdu_ctrl.sv
// mdu_ctrl: EX-stage multiply/divide sequencer owning the HI/LO registers.
// Multiplies take MUL_LAT cycles in MUL; divides run a 32-step restoring
// algorithm on magnitudes and fix up the signs on the final step.
module mdu_ctrl #(
  parameter int MUL_LAT = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic        req,
  input  logic        op_div,
  input  logic        op_sign,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        wr_hi,
  input  logic        wr_lo,
  input  logic [31:0] wr_data,
  output logic        stall,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quot_q, quot_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        sign_q, sign_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic        busy_q, busy_d;

  logic [31:0] abs_a, abs_b;
  logic [63:0] mul_a, mul_b, product;
  logic [32:0] rem_shift, rem_sub;
  logic        rem_ge;
  logic [31:0] rem_next, quot_next;

  // Datapath: operand magnitudes, the product, and one restoring divide step.
  // The remainder stays below the divisor, so only the shifted value needs
  // the 33rd bit; its borrow after subtraction tells whether it fit.
  always_comb begin
    abs_a     = (op_sign && src_a[31]) ? (32'd0 - src_a) : src_a;
    abs_b     = (op_sign && src_b[31]) ? (32'd0 - src_b) : src_b;
    mul_a     = {{32{sign_q & opa_q[31]}}, opa_q};
    mul_b     = {{32{sign_q & opb_q[31]}}, opb_q};
    product   = mul_a * mul_b;
    rem_shift = {rem_q, opa_q[31]};
    rem_sub   = rem_shift - {1'b0, opb_q};
    rem_ge    = ~rem_sub[32];
    rem_next  = rem_ge ? rem_sub[31:0] : rem_shift[31:0];
    quot_next = {quot_q[30:0], rem_ge};
  end

  // Next-state and register updates; mthi/mtlo first so a result write wins.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    rem_d   = rem_q;
    quot_d  = quot_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    sign_d  = sign_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;

    if (!flush && (state_q == S_IDLE || state_q == S_DONE)) begin
      if (wr_hi) hi_d = wr_data;
      if (wr_lo) lo_d = wr_data;
    end

    case (state_q)
      S_IDLE: begin
        if (req && !flush) begin
          sign_d = op_sign;
          if (op_div) begin
            opa_d   = abs_a;
            opb_d   = abs_b;
            qneg_d  = op_sign & (src_a[31] ^ src_b[31]);
            rneg_d  = op_sign & src_a[31];
            rem_d   = 32'd0;
            quot_d  = 32'd0;
            cnt_d   = 5'd31;
            state_d = S_DIV;
          end else begin
            opa_d   = src_a;
            opb_d   = src_b;
            cnt_d   = 5'(MUL_LAT - 1);
            state_d = S_MUL;
          end
        end
      end
      S_MUL: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (cnt_q == 5'd0) begin
          hi_d    = product[63:32];
          lo_d    = product[31:0];
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      S_DIV: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          rem_d  = rem_next;
          quot_d = quot_next;
          opa_d  = {opa_q[30:0], 1'b0};
          cnt_d  = cnt_q - 5'd1;
          if (cnt_q == 5'd0) begin
            lo_d    = qneg_q ? (32'd0 - quot_next) : quot_next;
            hi_d    = rneg_q ? (32'd0 - rem_next) : rem_next;
            state_d = S_DONE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_MUL) || (state_d == S_DIV);
  end

  // State and datapath registers, cleared asynchronously by resetn.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      opa_q   <= 32'd0;
      opb_q   <= 32'd0;
      rem_q   <= 32'd0;
      quot_q  <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      sign_q  <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      sign_q  <= sign_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      busy_q  <= busy_d;
    end
  end

  // Stall is combinational so a flush or reset releases the pipeline at once.
  always_comb begin
    stall = resetn & req & ~flush & (state_q != S_DONE);
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: scoreboard bench for mdu_ctrl; expected HI/LO come from a
// behavioural model and are queued at issue, then popped in the DONE cycle.
module tb_mdu_ctrl;

   localparam int MulLat = 1;

   logic        clk = 1'b0;
   logic        resetn;
   logic        flush;
   logic        req;
   logic        opDiv;
   logic        opSign;
   logic [31:0] srcA;
   logic [31:0] srcB;
   logic        wrHi;
   logic        wrLo;
   logic [31:0] wrData;
   logic        stall;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   int          checkCount = 0;
   int          passCount = 0;
   logic [63:0] expQ[$];
   logic [31:0] expHi = 32'd0;
   logic [31:0] expLo = 32'd0;

   mdu_ctrl #(.MUL_LAT(MulLat)) dut (
      .clk     (clk),
      .resetn  (resetn),
      .flush   (flush),
      .req     (req),
      .op_div  (opDiv),
      .op_sign (opSign),
      .src_a   (srcA),
      .src_b   (srcB),
      .wr_hi   (wrHi),
      .wr_lo   (wrLo),
      .wr_data (wrData),
      .stall   (stall),
      .busy    (busy),
      .hi      (hi),
      .lo      (lo)
   );

   // Free-running clock, rising edge active.
   always #5 clk = ~clk;

   // Watchdog so a stuck design still produces a verdict.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checkCount++;
      if (got === exp) passCount++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   // Reference model returning {hi, lo}.
   function automatic logic [63:0] modelOp(input bit isDiv, input bit isSigned,
                                           input logic [31:0] a, input logic [31:0] b);
      int     sa;
      int     sb;
      longint p;
      logic [31:0] q;
      logic [31:0] r;
      sa = a;
      sb = b;
      if (!isDiv) begin
         if (isSigned) begin
            p = longint'(sa) * longint'(sb);
            return 64'(p);
         end
         return {32'd0, a} * {32'd0, b};
      end
      if (b == 32'd0) begin
         q = (isSigned && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
         r = a;
      end else if (isSigned) begin
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
         end else begin
            q = 32'(sa / sb);
            r = 32'(sa % sb);
         end
      end else begin
         q = a / b;
         r = a % b;
      end
      return {r, q};
   endfunction

   task automatic applyStimulus(input bit isDiv, input bit isSigned,
                                input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      expQ.push_back(modelOp(isDiv, isSigned, a, b));
      opDiv  = isDiv;
      opSign = isSigned;
      srcA   = a;
      srcB   = b;
      req    = 1'b1;
   endtask

   task automatic collectResult(input string tag, input int expCycles);
      int          cycles;
      logic [63:0] r;
      cycles = 0;
      #1;
      while (stall && cycles < 80) begin
         checkOutput({tag, "_busy"}, 64'(busy), 64'(cycles != 0));
         cycles++;
         @(negedge clk);
         #1;
      end
      checkOutput({tag, "_stallCycles"}, 64'(cycles), 64'(expCycles));
      checkOutput({tag, "_doneBusy"}, 64'(busy), 64'd0);
      if (expQ.size() == 0) begin
         checkOutput({tag, "_queue"}, 64'd0, 64'd1);
      end else begin
         r = expQ.pop_front();
         expHi = r[63:32];
         expLo = r[31:0];
         checkOutput({tag, "_hi"}, 64'(hi), 64'(expHi));
         checkOutput({tag, "_lo"}, 64'(lo), 64'(expLo));
      end
      req = 1'b0;
   endtask

   task automatic runOp(input string tag, input bit isDiv, input bit isSigned,
                        input logic [31:0] a, input logic [31:0] b);
      applyStimulus(isDiv, isSigned, a, b);
      collectResult(tag, isDiv ? 33 : MulLat + 1);
   endtask

   // Main sequence.
   initial begin
      resetn = 1'b0;
      flush  = 1'b0;
      req    = 1'b0;
      opDiv  = 1'b0;
      opSign = 1'b0;
      srcA   = 32'd0;
      srcB   = 32'd0;
      wrHi   = 1'b0;
      wrLo   = 1'b0;
      wrData = 32'd0;
      repeat (2) @(negedge clk);
      checkOutput("rstHi", 64'(hi), 64'd0);
      checkOutput("rstLo", 64'(lo), 64'd0);
      checkOutput("rstStall", 64'(stall), 64'd0);
      checkOutput("rstBusy", 64'(busy), 64'd0);
      resetn = 1'b1;

      runOp("multNeg", 1'b0, 1'b1, 32'hFFFF_FFFD, 32'd5);
      runOp("divu", 1'b1, 1'b0, 32'd100, 32'd7);
      runOp("multuMax", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      runOp("divNeg", 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2);
      runOp("divOvf", 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      runOp("divuZero", 1'b1, 1'b0, 32'h0000_1234, 32'd0);
      runOp("divZeroNeg", 1'b1, 1'b1, 32'hFFFF_FFF8, 32'd0);
      runOp("divZeroPos", 1'b1, 1'b1, 32'd77, 32'd0);
      for (int i = 0; i < 6; i++) begin
         runOp($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               $urandom, $urandom_range(1, 32'hFFFF_FFFF));
      end

      // mthi preload, then abort a divide at iteration 10.
      @(negedge clk);
      wrHi   = 1'b1;
      wrData = 32'h0000_AAAA;
      @(negedge clk);
      wrHi  = 1'b0;
      expHi = 32'h0000_AAAA;
      checkOutput("mthi", 64'(hi), 64'(expHi));
      applyStimulus(1'b1, 1'b0, 32'd1000, 32'd3);
      for (int i = 0; i < 10; i++) @(negedge clk);
      flush = 1'b1;
      #1;
      checkOutput("flushStall", 64'(stall), 64'd0);
      checkOutput("flushBusyBefore", 64'(busy), 64'd1);
      @(negedge clk);
      flush = 1'b0;
      req   = 1'b0;
      void'(expQ.pop_back());
      #1;
      checkOutput("abortBusy", 64'(busy), 64'd0);
      checkOutput("abortHi", 64'(hi), 64'(expHi));
      checkOutput("abortLo", 64'(lo), 64'(expLo));

      // A flushed IDLE cycle must neither accept nor write LO.
      @(negedge clk);
      flush  = 1'b1;
      req    = 1'b1;
      opDiv  = 1'b0;
      wrLo   = 1'b1;
      wrData = 32'h0000_0077;
      @(negedge clk);
      flush = 1'b0;
      req   = 1'b0;
      wrLo  = 1'b0;
      #1;
      checkOutput("flushIdleBusy", 64'(busy), 64'd0);
      checkOutput("flushIdleLo", 64'(lo), 64'(expLo));
      @(negedge clk);
      wrLo   = 1'b1;
      wrData = 32'h0000_0055;
      @(negedge clk);
      wrLo  = 1'b0;
      expLo = 32'h0000_0055;
      checkOutput("mtlo", 64'(lo), 64'(expLo));

      // Reset in the middle of a divide.
      applyStimulus(1'b1, 1'b1, 32'hFFFF_FF9C, 32'd7);
      for (int i = 0; i < 5; i++) @(negedge clk);
      resetn = 1'b0;
      #1;
      checkOutput("midRstStall", 64'(stall), 64'd0);
      checkOutput("midRstBusy", 64'(busy), 64'd0);
      checkOutput("midRstHi", 64'(hi), 64'd0);
      checkOutput("midRstLo", 64'(lo), 64'd0);
      req = 1'b0;
      void'(expQ.pop_back());
      @(negedge clk);
      resetn = 1'b1;
      runOp("postRst", 1'b0, 1'b1, 32'h0001_0000, 32'hFFFF_0000);

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multiply/divide sequencer for the EX stage. It accepts a decoded `mult`/`multu`/`div`/`divu` request, runs a fixed-latency multiply or a 32-iteration restoring divide, and stalls the pipeline while it works. It owns the architectural HI/LO registers and applies `mthi`/`mtlo` writes. An exception flush aborts an in-flight operation without touching HI/LO.

## Interface
- `MUL_LAT`, default 1: cycles spent in the MUL state (1..4).
- `clk` in 1: clock, rising edge.
- `resetn` in 1: asynchronous active-low reset.
- `flush` in 1: kill the EX-stage instruction; aborts any operation.
- `req` in 1: EX instruction is mult/div (decode `FUNC_MUL`/`FUNC_DIV`). Held high until the stall clears.
- `op_div` in 1: 1 = divide, 0 = multiply.
- `op_sign` in 1: 1 = signed (`OPER_ALUS`), 0 = unsigned (`OPER_ALUU`).
- `src_a` in 32: rs operand (dividend / multiplicand).
- `src_b` in 32: rt operand (divisor / multiplier).
- `wr_hi` in 1: write HI (`mthi`).
- `wr_lo` in 1: write LO (`mtlo`).
- `wr_data` in 32: data for `wr_hi`/`wr_lo`.
- `stall` out 1: hold IF/ID/EX.
- `busy` out 1: state is MUL or DIV.
- `hi` out 32: architectural HI.
- `lo` out 32: architectural LO.

## Operation
- States: IDLE, MUL, DIV, DONE. Reset puts the block in IDLE with `hi`=`lo`=0, counter 0, `stall`=0, `busy`=0.
- IDLE, `req & ~flush`:
  - Latch the operands and `op_sign`.
  - Multiply: go to MUL with counter=`MUL_LAT`-1.
  - Divide: latch |a|, |b| (absolute values only when `op_sign`), quotient sign = a[31]^b[31], remainder sign = a[31]. Clear the 33-bit partial remainder and go to DIV with counter=31.
- MUL:
  - Compute the 64-bit product (signed or unsigned per `op_sign`).
  - At counter=0: write {hi,lo} ← product and go to DONE. Otherwise decrement the counter.
- DIV: one restoring step per cycle.
  - rem ← {rem[31:0], dividend[31]}; shift the dividend left.
  - If rem ≥ divisor: rem −= divisor and the quotient bit is 1; otherwise the bit is 0.
  - At counter=0: apply the signs, write lo ← quotient and hi ← remainder, go to DONE.
- DONE: `stall`=0 and the instruction leaves EX. Next state is IDLE unconditionally; `req` is ignored in DONE.
- `stall` = `req & ~flush & (state≠DONE)`, combinational. It is high in IDLE during the accept cycle.
- `wr_hi`/`wr_lo`:
  - Applied on the clock edge when `~flush`, in IDLE or DONE only. In MUL/DIV they are ignored; the pipeline is stalled, so they cannot legally arrive there.
  - If a write and a result write-back land on the same edge, the result wins.
- Divide by zero (natural restoring result):
  - Unsigned: lo=0xFFFFFFFF, hi=a.
  - Signed: lo=0xFFFFFFFF if a≥0, else 0x00000001; hi=a.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- `flush` in MUL/DIV: next state IDLE, HI/LO unchanged, `stall` drops in the flush cycle itself.
- `flush` in IDLE: suppresses the accept and any HI/LO write.
- `resetn` low mid-operation: immediately returns to IDLE with reset values.

## Timing
- Cycle 0 is the first cycle with `req` high in IDLE.
- Multiply:
  - `stall` is high for cycles 0..`MUL_LAT`.
  - HI/LO are updated at the end of cycle `MUL_LAT`; DONE is cycle `MUL_LAT`+1.
  - Default: 2 stall cycles.
- Divide:
  - `stall` is high for cycles 0..32: accept plus 32 iterations.
  - HI/LO are updated at the end of cycle 32; DONE is cycle 33.
- Back-to-back operations: the next `req` can be accepted no earlier than the cycle after DONE.
- `busy` is registered and high exactly in MUL/DIV.
- HI/LO results are visible to `mfhi`/`mflo` in the DONE cycle.

## Test plan
- Signed mult: a=0xFFFFFFFD (−3), b=5 → `stall` high 2 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- divu: a=100, b=7 → `stall` high 33 cycles, then lo=14, hi=2. Back-to-back multu 0xFFFFFFFF×0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- Signed div: a=−7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. a=0x80000000, b=−1 → lo=0x80000000, hi=0.
- Divide by zero:
  - divu a=0x1234, b=0 → lo=0xFFFFFFFF, hi=0x1234.
  - div a=−8, b=0 → lo=1, hi=0xFFFFFFF8.
- Abort: preload HI=0xAAAA via `mthi`, start div, assert `flush` at iteration 10 → `stall` low that cycle, IDLE next, hi=0xAAAA and lo unchanged. A later `mtlo` 0x55 gives lo=0x55.
- Reset mid-div: pull `resetn` low at iteration 5 → `stall`=0, `busy`=0, hi=lo=0 immediately.
